// File: rtl/audio_seq_pkg.sv
// Shared types and sizing for the audio frame sequencer.
// Frame geometry, config field widths and FSM state encoding.
`timescale 1ns/1ps
package audio_seq_pkg;

  localparam int LINES       = 64;
  localparam int LINE_W      = 512;
  localparam int IDX_W       = $clog2(LINES);
  localparam int COEFF_IDX_W = 11;
  localparam int COEFF_W     = 8;
  localparam int SEMI_W      = 5;
  localparam int READ_LAT    = 1;
  localparam int RUN_TIMEOUT = 13000;
  localparam int RUN_W       = $clog2(RUN_TIMEOUT);
  localparam int LAT_W       = $clog2(READ_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } seq_state_e;

endpackage

// File: rtl/audio_seq_if.sv
// Host stream bundle: input line channel and output line channel.
// The host is the master; the sequencer is the slave.
`timescale 1ns/1ps
interface audio_seq_if;
  import audio_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [LINE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/seq_out_stage.sv
// Result fetch stage: waits out the datapath read latency, then
// holds the captured line with valid until the host takes it.
`timescale 1ns/1ps
module seq_out_stage
  import audio_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [LINE_W-1:0] rd_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data
);

  logic             pend;
  logic [LAT_W-1:0] lat;

  // Latency countdown, capture, and hold-until-accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      lat       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (fetch) begin
        pend <= 1'b1;
        lat  <= LAT_W'(READ_LAT);
      end else if (pend) begin
        if (lat != '0) begin
          lat <= lat - LAT_W'(1);
        end else begin
          pend      <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= rd_data;
        end
      end
    end
  end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Frame sequencer: loads lines and config into the datapath,
// starts it, waits for done or timeout, then drains results.
`timescale 1ns/1ps
module audio_frame_sequencer
  import audio_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  audio_seq_if.slave             host,
  output logic                   cfg_ready,
  input  logic                   cfg_semi_valid,
  input  logic [SEMI_W-1:0]      cfg_semitones,
  input  logic                   cfg_coeff_valid,
  input  logic [COEFF_IDX_W-1:0] cfg_coeff_index,
  input  logic [COEFF_W-1:0]     cfg_coeff_data,
  output logic                   ap_data_wr_en,
  output logic [IDX_W-1:0]       ap_input_index,
  output logic [LINE_W-1:0]      ap_data_in,
  output logic                   ap_pitch_shift_wr_en,
  output logic [SEMI_W-1:0]      ap_pitch_shift_semitones,
  output logic                   ap_freq_coeff_wr_en,
  output logic [COEFF_IDX_W-1:0] ap_freq_coeff_index,
  output logic [COEFF_W-1:0]     ap_freq_coeff_in,
  output logic                   ap_start,
  input  logic                   ap_done,
  output logic [IDX_W-1:0]       ap_output_index,
  input  logic [LINE_W-1:0]      ap_data_out,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic                   timeout_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINES - 1);
  localparam logic [RUN_W-1:0] TLIM = RUN_W'(RUN_TIMEOUT - 1);

  seq_state_e       state;
  seq_state_e       state_n;
  logic [IDX_W-1:0] ld_idx;
  logic [RUN_W-1:0] run_cnt;
  logic             cfg_any;
  logic             in_hs;
  logic             out_hs;
  logic             fetch;
  logic             run_to;

  assign cfg_any = cfg_semi_valid | cfg_coeff_valid;
  assign cfg_ready = (state == S_IDLE);
  // Config wins over data in IDLE so both never land together.
  assign host.in_ready = (state == S_LOAD) |
                         ((state == S_IDLE) & ~cfg_any);
  assign in_hs  = host.in_valid & host.in_ready;
  assign out_hs = host.out_valid & host.out_ready;
  assign busy   = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, fetch requests and timeout detection.
  always_comb begin
    state_n = state;
    fetch   = 1'b0;
    run_to  = 1'b0;
    unique case (state)
      S_IDLE:  if (in_hs) state_n = S_LOAD;
      S_LOAD:  if (in_hs && ld_idx == LAST) state_n = S_START;
      S_START: state_n = S_RUN;
      S_RUN: begin
        unique case (1'b1)
          ap_done: begin
            state_n = S_DRAIN;
            fetch   = 1'b1;
          end
          (!ap_done && run_cnt == TLIM): begin
            state_n = S_DRAIN;
            fetch   = 1'b1;
            run_to  = 1'b1;
          end
          default: ;
        endcase
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (ap_output_index == LAST) state_n = S_IDLE;
          else                         fetch   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Input line writes into the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_idx         <= '0;
      ap_data_wr_en  <= 1'b0;
      ap_input_index <= '0;
      ap_data_in     <= '0;
    end else begin
      ap_data_wr_en <= in_hs;
      if (in_hs) begin
        ap_input_index <= ld_idx;
        ap_data_in     <= host.in_data;
        ld_idx <= (ld_idx == LAST) ? '0 : ld_idx + IDX_W'(1);
      end
    end
  end

  // Config writes, accepted only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ap_pitch_shift_wr_en     <= 1'b0;
      ap_pitch_shift_semitones <= '0;
      ap_freq_coeff_wr_en      <= 1'b0;
      ap_freq_coeff_index      <= '0;
      ap_freq_coeff_in         <= '0;
    end else begin
      ap_pitch_shift_wr_en <= cfg_ready & cfg_semi_valid;
      ap_freq_coeff_wr_en  <= cfg_ready & cfg_coeff_valid;
      if (cfg_ready && cfg_semi_valid)
        ap_pitch_shift_semitones <= cfg_semitones;
      if (cfg_ready && cfg_coeff_valid) begin
        ap_freq_coeff_index <= cfg_coeff_index;
        ap_freq_coeff_in    <= cfg_coeff_data;
      end
    end
  end

  // Start pulse, run timer, drain index and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      ap_start        <= 1'b0;
      run_cnt         <= '0;
      timeout_err     <= 1'b0;
      ap_output_index <= '0;
      frame_count     <= '0;
    end else begin
      ap_start    <= (state == S_START);
      run_cnt     <= (state == S_RUN) ? run_cnt + RUN_W'(1) : '0;
      timeout_err <= timeout_err | run_to;
      if (state == S_DRAIN && out_hs) begin
        if (ap_output_index == LAST) begin
          ap_output_index <= '0;
          frame_count     <= frame_count + 16'd1;
        end else begin
          ap_output_index <= ap_output_index + IDX_W'(1);
        end
      end
    end
  end

  seq_out_stage u_out (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .rd_data   (ap_data_out),
    .out_ready (host.out_ready),
    .out_valid (host.out_valid),
    .out_data  (host.out_data)
  );

endmodule
